// File: rtl/adder_16bit_seq_if.sv
// rtl/adder_16bit_seq_if.sv - operand/result handshake bundle for adder_16bit_seq (OV present with ADDER_OVF_EN)
interface adder_16bit_seq_if #(
   parameter int WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH:1]   A;
   logic [WIDTH:1]   B;
   logic             C_in;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH:1]   S;
   logic             C_out;
`ifdef ADDER_OVF_EN
   logic             OV;
`endif

   modport master (
      output in_valid, A, B, C_in, out_ready,
      input  in_ready, out_valid, S, C_out
`ifdef ADDER_OVF_EN
      , OV
`endif
   );

   modport slave (
      input  in_valid, A, B, C_in, out_ready,
      output in_ready, out_valid, S, C_out
`ifdef ADDER_OVF_EN
      , OV
`endif
   );
endinterface

// File: rtl/adder_16bit_seq.sv
// rtl/adder_16bit_seq.sv - multi-cycle slice-serial adder with valid/ready handshake; ADDER_OVF_EN adds OV
module adder_16bit_seq #(
   parameter int WIDTH = 16,
   parameter int SLICE = 4
) (
   input logic              clk,
   input logic              rst,
   adder_16bit_seq_if.slave bus
);
   localparam int NSL  = WIDTH / SLICE;
   localparam int IDXW = (NSL > 1) ? $clog2(NSL) : 1;
   localparam logic [IDXW-1:0] LAST = IDXW'(NSL - 1);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t           state;
   state_t           next_state;
   logic [WIDTH:1]   a_r;
   logic [WIDTH:1]   b_r;
   logic [WIDTH:1]   partial_r;
   logic [WIDTH:1]   next_partial;
   logic             carry_r;
   logic [IDXW-1:0]  idx;
   logic [SLICE:0]   slice_sum;
   logic [WIDTH:1]   s_r;
   logic             c_out_r;
`ifdef ADDER_OVF_EN
   logic             ov_r;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= IDLE;
      else
         state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (bus.in_valid)  next_state = BUSY;
         BUSY:    if (idx == LAST)   next_state = DONE;
         DONE:    if (bus.out_ready) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // One slice per BUSY cycle; the final slice is merged into next_partial so S never shows a partial sum.
   always_comb begin
      slice_sum = {1'b0, a_r[int'(idx)*SLICE+1 +: SLICE]}
                + {1'b0, b_r[int'(idx)*SLICE+1 +: SLICE]}
                + {{SLICE{1'b0}}, carry_r};
      next_partial = partial_r;
      next_partial[int'(idx)*SLICE+1 +: SLICE] = slice_sum[SLICE-1:0];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_r       <= '0;
         b_r       <= '0;
         partial_r <= '0;
         carry_r   <= 1'b0;
         idx       <= '0;
         s_r       <= '0;
         c_out_r   <= 1'b0;
`ifdef ADDER_OVF_EN
         ov_r      <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  a_r       <= bus.A;
                  b_r       <= bus.B;
                  carry_r   <= bus.C_in;
                  partial_r <= '0;
                  idx       <= '0;
               end
            end
            BUSY: begin
               partial_r <= next_partial;
               carry_r   <= slice_sum[SLICE];
               idx       <= idx + 1'b1;
               if (idx == LAST) begin
                  s_r     <= next_partial;
                  c_out_r <= slice_sum[SLICE];
`ifdef ADDER_OVF_EN
                  // Carry into the MSB recovered from the MSB sum bit, then XOR with carry out.
                  ov_r    <= a_r[WIDTH] ^ b_r[WIDTH] ^ next_partial[WIDTH] ^ slice_sum[SLICE];
`endif
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.in_ready  = (state == IDLE);
   assign bus.out_valid = (state == DONE);
   assign bus.S         = s_r;
   assign bus.C_out     = c_out_r;
`ifdef ADDER_OVF_EN
   assign bus.OV        = ov_r;
`endif
endmodule

// File: tb/tb_adder_16bit_seq.sv
// tb/tb_adder_16bit_seq.sv - directed table-driven bench for adder_16bit_seq
module tb_adder_16bit_seq;
   logic clk;
   logic rst;
   int   errors;
   int   checks;

   adder_16bit_seq_if #(.WIDTH(16)) bus ();

   adder_16bit_seq #(.WIDTH(16), .SLICE(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic        cin;
      logic [15:0] s;
      logic        c;
      logic        ov;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_result(input string tag, input logic [15:0] s, input logic c, input logic ov);
      chk({tag, " S"}, 32'(bus.S), 32'(s));
      chk({tag, " C_out"}, 32'(bus.C_out), 32'(c));
`ifdef ADDER_OVF_EN
      chk({tag, " OV"}, 32'(bus.OV), 32'(ov));
`endif
   endtask

   // Accept one operand set, verify exact 4-edge latency and the result, then consume it.
   task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic cin, input logic [15:0] s, input logic c, input logic ov);
      bus.A = a;
      bus.B = b;
      bus.C_in = cin;
      bus.in_valid = 1'b1;
      chk({tag, " in_ready pre"}, 32'(bus.in_ready), 32'd1);
      tick();
      bus.in_valid = 1'b0;
      bus.A = ~a;
      bus.B = 16'h5A5A;
      bus.C_in = ~cin;
      chk({tag, " in_ready busy"}, 32'(bus.in_ready), 32'd0);
      for (int k = 1; k <= 4; k++) begin
         if (k > 1) tick();
         if (k < 4) chk({tag, " out_valid early"}, 32'(bus.out_valid), 32'd0);
      end
      tick();
      chk({tag, " out_valid"}, 32'(bus.out_valid), 32'd1);
      check_result(tag, s, c, ov);
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      chk({tag, " out_valid drop"}, 32'(bus.out_valid), 32'd0);
      chk({tag, " in_ready idle"}, 32'(bus.in_ready), 32'd1);
      check_result({tag, " hold"}, s, c, ov);
   endtask

   vec_t vecs[8];

   initial begin
      errors = 0;
      checks = 0;
      vecs[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
      vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
      vecs[2] = '{16'h0FFF, 16'h0000, 1'b1, 16'h1000, 1'b0, 1'b0};
      vecs[3] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
      vecs[4] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
      vecs[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
      vecs[6] = '{16'hABCD, 16'h1234, 1'b0, 16'hBE01, 1'b0, 1'b0};
      vecs[7] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};

      rst = 1'b1;
      bus.in_valid = 1'b1;
      bus.A = 16'h1111;
      bus.B = 16'h2222;
      bus.C_in = 1'b0;
      bus.out_ready = 1'b0;
      tick();
      tick();
      chk("reset out_valid", 32'(bus.out_valid), 32'd0);
      chk("reset S", 32'(bus.S), 32'd0);
      chk("reset C_out", 32'(bus.C_out), 32'd0);
      chk("reset in_ready", 32'(bus.in_ready), 32'd1);
      bus.in_valid = 1'b0;
      rst = 1'b0;
      tick();
      chk("post reset no accept", 32'(bus.in_ready), 32'd1);

      for (int i = 0; i < 8; i++)
         run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin,
                vecs[i].s, vecs[i].c, vecs[i].ov);

      // Backpressure: DONE holds for 10 cycles while inputs churn.
      bus.A = 16'h1234;
      bus.B = 16'h4321;
      bus.C_in = 1'b0;
      bus.in_valid = 1'b1;
      tick();
      repeat (4) tick();
      for (int k = 0; k < 10; k++) begin
         bus.in_valid = k[0];
         bus.A = 16'(k * 16'h1111);
         bus.B = 16'(~k);
         chk("bp out_valid", 32'(bus.out_valid), 32'd1);
         chk("bp in_ready", 32'(bus.in_ready), 32'd0);
         chk("bp S", 32'(bus.S), 32'h5555);
         chk("bp C_out", 32'(bus.C_out), 32'd0);
         tick();
      end
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      chk("bp release out_valid", 32'(bus.out_valid), 32'd0);
      chk("bp release in_ready", 32'(bus.in_ready), 32'd1);
      chk("bp release S hold", 32'(bus.S), 32'h5555);

      // Reset after two slices of a carry-heavy add.
      bus.A = 16'hFFFF;
      bus.B = 16'h0001;
      bus.C_in = 1'b0;
      bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      #1;
      chk("midrst out_valid", 32'(bus.out_valid), 32'd0);
      chk("midrst S", 32'(bus.S), 32'd0);
      chk("midrst C_out", 32'(bus.C_out), 32'd0);
      chk("midrst in_ready", 32'(bus.in_ready), 32'd1);
      tick();
      rst = 1'b0;
      tick();
      run_op("after rst", 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0);

      // Back-to-back: in_valid and out_ready held high, one result per 6 cycles.
      bus.out_ready = 1'b1;
      bus.in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         bus.A = vecs[i + 3].a;
         bus.B = vecs[i + 3].b;
         bus.C_in = vecs[i + 3].cin;
         tick();
         chk("b2b accepted", 32'(bus.in_ready), 32'd0);
         bus.A = 16'hDEAD;
         repeat (4) tick();
         chk("b2b out_valid", 32'(bus.out_valid), 32'd1);
         check_result($sformatf("b2b%0d", i), vecs[i + 3].s, vecs[i + 3].c, vecs[i + 3].ov);
         tick();
         chk("b2b drop", 32'(bus.out_valid), 32'd0);
         chk("b2b in_ready", 32'(bus.in_ready), 32'd1);
      end
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b0;
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
